// File: rtl/int2float_seq_if.sv
// rtl/int2float_seq_if.sv - handshake bundle for the integer-to-float converter
interface int2float_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inputi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  // Producer/consumer side: drives operands, accepts results
  modport master (
    output in_valid,
    output inputi,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
  );

  // Converter side
  modport slave (
    input  in_valid,
    input  inputi,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
  );
endinterface

// File: rtl/int2float_seq.sv
// rtl/int2float_seq.sv - multi-cycle 32-bit integer to IEEE-754 single converter, RNE
module int2float_seq #(
  parameter bit SIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  int2float_seq_if.slave  io
);

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  logic [31:0] neg_mag;
  logic        round_up;
  logic [23:0] mant_inc;
  logic [22:0] mant_fin;
  logic [7:0]  exp_fin;

  // Round-to-nearest-even on the normalized magnitude; a carry out of the
  // 23-bit mantissa leaves it zero and bumps the exponent by one.
  always_comb begin
    neg_mag  = ~mag_q + 32'd1;
    round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    mant_inc = {1'b0, mag_q[30:8]} + {23'd0, round_up};
    mant_fin = mant_inc[22:0];
    exp_fin  = exp_q + {7'd0, mant_inc[23]};
  end

  // Next-state and registered-output computation for the conversion FSM
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    zero_d      = zero_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          mag_d   = io.inputi;
          state_d = ABS;
        end
      end
      ABS: begin
        // -2^31 negates to itself, which is the correct unsigned magnitude
        sign_d  = SIGNED & mag_q[31];
        mag_d   = (SIGNED & mag_q[31]) ? neg_mag : mag_q;
        exp_d   = 8'd158;
        zero_d  = (mag_q == 32'd0);
        state_d = (mag_q == 32'd0) ? ROUND : NORM;
      end
      NORM: begin
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        // Zero always yields +0.0, never a negative zero
        result_d    = zero_q ? 32'd0 : {sign_q, exp_fin, mant_fin};
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_valid_q && io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is registered so it only rises on the edge that enters IDLE
    in_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 32'd0;
      exp_q       <= 8'd0;
      zero_q      <= 1'b0;
      result_q    <= 32'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      zero_q      <= zero_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;

endmodule

// File: tb/tb_int2float_seq.sv
// tb/tb_int2float_seq.sv - self-checking bench for int2float_seq (signed and unsigned)
module tb_int2float_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  int2float_seq_if if_s ();
  int2float_seq_if if_u ();

  int2float_seq #(.SIGNED(1'b1)) u_s (.clk(clk), .rst_n(rst_n), .io(if_s.slave));
  int2float_seq #(.SIGNED(1'b0)) u_u (.clk(clk), .rst_n(rst_n), .io(if_u.slave));

  // Index 0 = signed instance, index 1 = unsigned instance
  logic        iv   [2];
  logic [31:0] xi   [2];
  logic        ordy [2];
  logic        ov   [2];
  logic        ir   [2];
  logic [31:0] res  [2];

  assign if_s.in_valid  = iv[0];
  assign if_s.inputi    = xi[0];
  assign if_s.out_ready = ordy[0];
  assign if_u.in_valid  = iv[1];
  assign if_u.inputi    = xi[1];
  assign if_u.out_ready = ordy[1];
  assign ov[0]  = if_s.out_valid;
  assign ir[0]  = if_s.in_ready;
  assign res[0] = if_s.result;
  assign ov[1]  = if_u.out_valid;
  assign ir[1]  = if_u.in_ready;
  assign res[1] = if_u.result;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] lit_res [2];
  int          lit_lat [2];

  // Reference: exact magnitude, locate MSB, keep 24 significant bits, RNE on the rest
  function automatic logic [31:0] model_res(input logic [31:0] x, input bit sm);
    logic        neg;
    logic [63:0] m, q, rem, half;
    int          p, e, s;
    neg = sm && x[31];
    m   = neg ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
    if (m == 64'd0) return 32'd0;
    p = 63;
    while (m[p] == 1'b0) p--;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      s    = p - 23;
      q    = m >> s;
      rem  = m & ((64'd1 << s) - 64'd1);
      half = 64'd1 << (s - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {neg, e[7:0], q[22:0]};
  endfunction

  // Accept-to-out_valid edge count: 2 for zero, leading zeros + 3 otherwise
  function automatic int model_lat(input logic [31:0] x, input bit sm);
    logic [31:0] m;
    int          lz;
    m = (sm && x[31]) ? (~x + 32'd1) : x;
    if (m == 32'd0) return 2;
    lz = 0;
    while (m[31 - lz] == 1'b0) lz++;
    return lz + 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Single compare process: samples both DUTs on the falling edge
  initial begin : compare
    bit          busy    [2];
    bit          holding [2];
    int          edges   [2];
    logic [31:0] exp_res [2];
    logic [31:0] exp_lit [2];
    int          exp_lat [2];
    int          exp_ll  [2];
    logic [31:0] held    [2];
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0;
      holding[k] = 1'b0;
      edges[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          busy[i]    = 1'b0;
          holding[i] = 1'b0;
          chk("rst_out_valid", 32'(ov[i]), 32'd0);
          chk("rst_result", res[i], 32'd0);
          chk("rst_in_ready", 32'(ir[i]), 32'd0);
        end else begin
          if (busy[i]) begin
            edges[i]++;
            if (ov[i] === 1'b1) begin
              chk("result_model", res[i], exp_res[i]);
              chk("result_literal", res[i], exp_lit[i]);
              chk("latency_model", 32'(edges[i]), 32'(exp_lat[i]));
              chk("latency_literal", 32'(edges[i]), 32'(exp_ll[i]));
              chk("busy_in_ready", 32'(ir[i]), 32'd0);
              busy[i]    = 1'b0;
              holding[i] = 1'b1;
              held[i]    = res[i];
            end else if (edges[i] > 60) begin
              chk("timeout_out_valid", 32'd0, 32'd1);
              busy[i] = 1'b0;
            end
          end else if (holding[i]) begin
            if (ov[i] === 1'b1) begin
              chk("hold_result", res[i], held[i]);
              chk("hold_in_ready", 32'(ir[i]), 32'd0);
            end else begin
              holding[i] = 1'b0;
            end
          end else begin
            chk("idle_out_valid", 32'(ov[i]), 32'd0);
          end
          if (iv[i] === 1'b1 && ir[i] === 1'b1 && !busy[i] && !holding[i]) begin
            busy[i]    = 1'b1;
            edges[i]   = -1;
            exp_res[i] = model_res(xi[i], (i == 0));
            exp_lat[i] = model_lat(xi[i], (i == 0));
            exp_lit[i] = lit_res[i];
            exp_ll[i]  = lit_lat[i];
          end
        end
      end
    end
  end

  // Drive one operand, wait for the result, optionally stall with in_valid noise
  task automatic run_vec(input int i, input logic [31:0] x, input logic [31:0] lres,
                         input int llat, input int hold);
    int g;
    lit_res[i] = lres;
    lit_lat[i] = llat;
    xi[i] = x;
    iv[i] = 1'b1;
    g = 0;
    while (ir[i] !== 1'b1 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    iv[i] = 1'b0;
    xi[i] = $urandom;
    g = 0;
    while (ov[i] !== 1'b1 && g < 80) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (hold) begin
      @(posedge clk); #1;
      iv[i] = ~iv[i];
      xi[i] = $urandom;
    end
    iv[i]   = 1'b0;
    ordy[i] = 1'b1;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
  endtask

  initial begin : driver
    int g;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      xi[k] = 32'd0;
      ordy[k] = 1'b0;
      lit_res[k] = 32'd0;
      lit_lat[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec(0, 32'h0000_0001, 32'h3F80_0000, 34, 0);
    run_vec(0, 32'hFFFF_FFFF, 32'hBF80_0000, 34, 0);
    run_vec(0, 32'h0000_0000, 32'h0000_0000,  2, 0);
    run_vec(0, 32'h8000_0000, 32'hCF00_0000,  3, 0);
    run_vec(0, 32'h7FFF_FFFF, 32'h4F00_0000,  4, 0);
    run_vec(0, 32'h0100_0001, 32'h4B80_0000, 10, 0);
    run_vec(0, 32'h0100_0003, 32'h4B80_0002, 10, 0);
    run_vec(0, 32'h0000_0003, 32'h4040_0000, 33, 0);
    run_vec(0, 32'hFFFF_FFFB, 32'hC0A0_0000, 32, 0);
    run_vec(0, 32'h7FFF_FFC0, 32'h4F00_0000,  4, 0);
    run_vec(0, 32'h00FF_FFFF, 32'h4B7F_FFFF, 11, 0);
    run_vec(1, 32'hFFFF_FFFF, 32'h4F80_0000,  3, 0);
    run_vec(1, 32'h8000_0000, 32'h4F00_0000,  3, 0);
    run_vec(1, 32'h0000_0000, 32'h0000_0000,  2, 0);
    run_vec(1, 32'h0000_0064, 32'h42C8_0000, 28, 0);

    // Backpressure, then the next operand must still convert
    run_vec(0, 32'h0000_0064, 32'h42C8_0000, 28, 10);
    run_vec(0, 32'h0000_0010, 32'h4180_0000, 30, 0);

    // Reset asserted mid-NORM, between clock edges
    xi[0] = 32'h0000_0010;
    iv[0] = 1'b1;
    g = 0;
    while (ir[0] !== 1'b1 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    run_vec(0, 32'h0000_0010, 32'h4180_0000, 30, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int2float_seq.md
Name: int2float_seq

Overview:
- Multi-cycle converter from a 32-bit integer to IEEE-754 single precision.
- It is the inverse companion of the float floor/truncate path: floor yields integer-valued floats, and this block turns integers back into floats.
- Uses a valid/ready handshake on both sides, normalizes one bit per cycle, and rounds to nearest-even.
- Sits beside the CORDIC float datapath for int-to-float operand preparation.

Parameters:
- SIGNED, 1, 1 = input is two's complement; 0 = input is unsigned.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  inputi is valid
- in_ready  output  1  block can accept; high only in IDLE
- inputi  input  32  integer operand
- out_valid  output  1  result is valid; held until accepted
- out_ready  input  1  consumer accepts result
- result  output  32  IEEE-754 single: sign, exponent[30:23], mantissa[22:0]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=0 while rst_n low, 1 from first edge after release.
  - out_valid=0, result=0, internal regs cleared.
  - Reset mid-operation aborts the conversion; no output is produced.
- States: IDLE, ABS, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at an edge: capture inputi, go to ABS.
- ABS (1 cycle):
  - sign = SIGNED & inputi[31].
  - mag = sign ? (~inputi+1) : inputi, a 32-bit unsigned magnitude (so -2^31 gives 0x80000000).
  - exp = 158 (127+31).
  - If mag==0 go to ROUND with zero flag set; else go to NORM.
- NORM:
  - Each cycle, if mag[31]==0: mag<<=1, exp-=1, stay.
  - If mag[31]==1: go to ROUND without shifting.
  - Occupies lz+1 cycles, lz = leading zeros of mag (0..31).
- ROUND (1 cycle):
  - mant = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Round up iff guard & (sticky | mant[0]).
  - If the increment overflows mant (all ones), mant=0 and exp+=1.
  - result = {sign, exp[7:0], mant}; zero flag gives result = 0x00000000 (+0.0, never -0).
  - out_valid=1, go to DONE.
- DONE:
  - result and out_valid are held stable.
  - When out_valid&out_ready at an edge: out_valid=0, go to IDLE. in_ready is high the following cycle.
- Latency, counted from the accepting edge to the edge that raises out_valid:
  - Nonzero input: lz+3 edges (min 3, max 34).
  - Zero input: 2 edges.
- Exponent width: 8 bits internally, no overflow possible, range 127..158.
- No exceptions, NaN or Inf are generated; all 32-bit integers are representable after rounding.
- in_valid while busy is ignored (in_ready=0). inputi need only be stable on the accepting edge.

Test Plan:
- SIGNED=1, inputi=0x00000001 -> result 0x3F800000, out_valid 34 edges after accept; inputi=0xFFFFFFFF -> 0xBF800000.
- inputi=0x00000000 -> result 0x00000000 after 2 edges; inputi=0x80000000 -> 0xCF000000 after 3 edges.
- Rounding:
  - 0x7FFFFFFF -> 0x4F000000 (mantissa overflow bumps exponent).
  - 0x01000001 -> 0x4B800000 (tie, round to even).
  - 0x01000003 -> 0x4B800002 (tie, round up to even).
- SIGNED=0, inputi=0xFFFFFFFF -> 0x4F800000; inputi=0x80000000 -> 0x4F000000.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result and out_valid stable, in_ready=0, in_valid pulses ignored. On out_ready=1, IDLE resumes and the next operand converts correctly.
- rst_n pulsed low during NORM for inputi=0x00000010 -> out_valid, result, in_ready all 0 immediately (async). After release, no stale output appears and a fresh 0x00000010 converts to 0x41800000.
